// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: access sizes,
// arbiter FSM states, the latched request record and the alignment rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    mem_access_size_t size;
    logic [31:0]      wdata;
  } mem_req_t;

  // HALF needs addr[0]==0, WORD needs addr[1:0]==0; BYTE is always aligned.
  function automatic logic is_misaligned(input mem_access_size_t size,
                                         input logic [1:0] addr_lo);
    case (size)
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return |addr_lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_if.sv
// Single-ported memory interface. The arbiter side (slave modport) drives
// the read address/size and the write strobe/fields; the memory returns a
// sized, zero-extended rd_data combinationally.
interface mem_if;
  import mem_arbiter_pkg::*;

  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic             wr_enable;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;

  modport slave (
    output rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
    input  rd_data
  );

  modport memory (
    input  rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational. A sole requester
// wins outright; on a tie the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection from the request vector and last winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_if port between instruction fetch (port 0) and data
// access (port 1). One access at a time: IDLE -> BUSY -> RESP -> IDLE,
// with BUSY lasting WAIT_CYCLES+1 cycles to model memory latency.
// Optional feature macro: MEM_ARB_STATS_EN (grant/conflict counters).
//
// Handshake: a request on port p transfers on a rising edge where
// req_valid_i[p] and req_ready_o[p] are both high. Ready is only raised in
// IDLE, for at most one port, and never while reset_i is high. Requesters
// keep fields stable while valid and not ready, and may drop valid before
// ready. The response is a single-cycle resp_valid_o pulse with no
// backpressure.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][31:0]       req_addr_i,
  input  mem_access_size_t [1:0] req_size_i,
  input  logic [1:0][31:0]       req_wdata_i,
  output logic [1:0]             resp_valid_o,
  output logic [31:0]            resp_rdata_o,
  output logic                   resp_err_o,
`ifdef MEM_ARB_STATS_EN
  output logic [STAT_W-1:0]      stat_grant0_o,
  output logic [STAT_W-1:0]      stat_grant1_o,
  output logic [STAT_W-1:0]      stat_conflict_o,
`endif
  output mem_arb_state_t         dbg_state_o,
  mem_if.slave                   memif
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_arb_state_t   state_q, state_d;
  mem_req_t         req_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [1:0] grant;
  logic       g_idx;
  logic       accept;
  logic       mis_q;
  logic       done;

  rr_arbiter2 u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign g_idx       = grant[1];
  assign accept      = (state_q == IDLE) && (grant != 2'b00) && !reset_i;
  assign mis_q       = is_misaligned(req_q.size, req_q.addr[1:0]);
  assign done        = (state_q == BUSY) && (cnt_q == '0);
  assign dbg_state_o = state_q;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state plus all handshake, response and memory-port outputs.
  always_comb begin
    state_d          = state_q;
    req_ready_o      = 2'b00;
    resp_valid_o     = 2'b00;
    resp_rdata_o     = 32'h0;
    resp_err_o       = 1'b0;
    memif.rd_addr    = 32'h0;
    memif.rd_size    = MEM_WORD;
    memif.wr_enable  = 1'b0;
    memif.wr_addr    = 32'h0;
    memif.wr_size    = MEM_WORD;
    memif.wr_data    = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready_o = grant & {2{~reset_i}};
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        memif.rd_addr   = req_q.addr;
        memif.rd_size   = req_q.size;
        memif.wr_addr   = req_q.addr;
        memif.wr_size   = req_q.size;
        memif.wr_data   = req_q.wdata;
        // The write commits on the single edge that ends the BUSY phase.
        memif.wr_enable = done && req_q.we && !mis_q;
        if (done) state_d = RESP;
      end
      RESP: begin
        resp_valid_o[owner_q] = 1'b1;
        resp_rdata_o          = rdata_q;
        resp_err_o            = err_q;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait-state counter and response capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else if (accept) begin
      req_q.we     <= req_we_i[g_idx];
      req_q.addr   <= req_addr_i[g_idx];
      req_q.size   <= req_size_i[g_idx];
      req_q.wdata  <= req_wdata_i[g_idx];
      owner_q      <= g_idx;
      last_grant_q <= g_idx;
      cnt_q        <= CNT_W'(WAIT_CYCLES);
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        err_q   <= mis_q;
        rdata_q <= (req_q.we || mis_q) ? 32'h0 : memif.rd_data;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Free-running grant and tie counters, wrapping at 2^STAT_W.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_grant0_o   <= '0;
      stat_grant1_o   <= '0;
      stat_conflict_o <= '0;
    end else begin
      if (accept && !g_idx) stat_grant0_o <= stat_grant0_o + STAT_W'(1);
      if (accept && g_idx)  stat_grant1_o <= stat_grant1_o + STAT_W'(1);
      if (state_q == IDLE && req_valid_i == 2'b11)
        stat_conflict_o <= stat_conflict_o + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with WAIT_CYCLES=2 (table of accesses,
// tie arbitration, reset during a write) and one with WAIT_CYCLES=0
// (back-to-back reads). Each instance has its own byte-array memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int WAIT = 2;
  localparam int W    = 35;  // {owner, wr_pulses, err, rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with WAIT_CYCLES=2 ----------------
  logic [1:0]             req_valid = 2'b00;
  logic [1:0]             req_ready;
  logic [1:0]             req_we = 2'b00;
  logic [1:0][31:0]       req_addr = '0;
  mem_access_size_t [1:0] req_size = {MEM_WORD, MEM_WORD};
  logic [1:0][31:0]       req_wdata = '0;
  logic [1:0]             resp_valid;
  logic [31:0]            resp_rdata;
  logic                   resp_err;
  mem_arb_state_t         dbg_state;
  mem_if                  mif ();

  // ---------------- DUT with WAIT_CYCLES=0 ----------------
  logic [1:0]             req0_valid = 2'b00;
  logic [1:0]             req0_ready;
  logic [1:0]             req0_we = 2'b00;
  logic [1:0][31:0]       req0_addr = '0;
  mem_access_size_t [1:0] req0_size = {MEM_WORD, MEM_WORD};
  logic [1:0][31:0]       req0_wdata = '0;
  logic [1:0]             resp0_valid;
  logic [31:0]            resp0_rdata;
  logic                   resp0_err;
  mem_arb_state_t         dbg0_state;
  mem_if                  mif0 ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] st_g0, st_g1, st_cf, st0_g0, st0_g1, st0_cf;
`endif

  mem_arbiter #(.WAIT_CYCLES(WAIT), .STAT_W(32)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
`ifdef MEM_ARB_STATS_EN
    .stat_grant0_o(st_g0), .stat_grant1_o(st_g1), .stat_conflict_o(st_cf),
`endif
    .dbg_state_o(dbg_state), .memif(mif)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .STAT_W(32)) dut0 (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req0_valid), .req_ready_o(req0_ready), .req_we_i(req0_we),
    .req_addr_i(req0_addr), .req_size_i(req0_size), .req_wdata_i(req0_wdata),
    .resp_valid_o(resp0_valid), .resp_rdata_o(resp0_rdata), .resp_err_o(resp0_err),
`ifdef MEM_ARB_STATS_EN
    .stat_grant0_o(st0_g0), .stat_grant1_o(st0_g1), .stat_conflict_o(st0_cf),
`endif
    .dbg_state_o(dbg0_state), .memif(mif0)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem  [0:1023];
  logic [7:0] mem0 [0:1023];
  logic [9:0] ra, ra0, wa;

  function automatic logic [31:0] sized(input mem_access_size_t s, input logic [31:0] w);
    case (s)
      MEM_BYTE: return {24'h0, w[7:0]};
      MEM_HALF: return {16'h0, w[15:0]};
      default:  return w;
    endcase
  endfunction

  always_comb begin
    ra = mif.rd_addr[9:0];
    mif.rd_data = sized(mif.rd_size, {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]});
  end

  always_comb begin
    ra0 = mif0.rd_addr[9:0];
    mif0.rd_data = sized(mif0.rd_size, {mem0[ra0 + 10'd3], mem0[ra0 + 10'd2], mem0[ra0 + 10'd1], mem0[ra0]});
  end

  assign wa = mif.wr_addr[9:0];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'hEF; mem[10'h101] <= 8'hBE; mem[10'h102] <= 8'hAD; mem[10'h103] <= 8'hDE;
      mem[10'h200] <= 8'h44; mem[10'h201] <= 8'h33; mem[10'h202] <= 8'h22; mem[10'h203] <= 8'h11;
    end else if (mif.wr_enable) begin
      mem[wa] <= mif.wr_data[7:0];
      if (mif.wr_size != MEM_BYTE) mem[wa + 10'd1] <= mif.wr_data[15:8];
      if (mif.wr_size == MEM_WORD) begin
        mem[wa + 10'd2] <= mif.wr_data[23:16];
        mem[wa + 10'd3] <= mif.wr_data[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= 8'h00;
      mem0[10'h100] <= 8'hEF; mem0[10'h101] <= 8'hBE; mem0[10'h102] <= 8'hAD; mem0[10'h103] <= 8'hDE;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int hs_q[$];
  int wen_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops one expectation per resp_valid pulse.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int h;
    if (!rst) begin
      if (mif.wr_enable) wen_cnt <= wen_cnt + 1;
      if (dbg_state != IDLE) chk("ready_outside_idle", {30'h0, req_ready}, 32'h0);
      if (req_ready != 2'b00) chk("ready_onehot", {31'h0, $onehot(req_ready)}, 32'h1);
      if (resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {30'h0, resp_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          h = hs_q.pop_front();
          chk("resp_valid", {30'h0, resp_valid}, e[34] ? 32'h2 : 32'h1);
          chk("resp_rdata", resp_rdata, e[31:0]);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
          chk("wr_pulses", wen_cnt, {31'h0, e[33]});
          chk("latency", cyc - h, WAIT + 2);
        end
        wen_cnt <= 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic p, input logic we, input logic [31:0] addr,
                           input mem_access_size_t size, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int waited = 0;
    @(negedge clk);
    req_we[p] = we; req_addr[p] = addr; req_size[p] = size; req_wdata[p] = wdata;
    req_valid[p] = 1'b1;
    #1;
    while (!req_ready[p] && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (!req_ready[p]) begin
      chk("grant_timeout", 32'h0, 32'h1);
      req_valid[p] = 1'b0;
      return;
    end
    exp_q.push_back({p, we & ~exp_err, exp_err, exp_rdata});
    hs_q.push_back(cyc);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("drain", exp_q.size(), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             port;
    logic             we;
    logic [31:0]      addr;
    mem_access_size_t size;
    logic [31:0]      wdata;
    logic [31:0]      exp_rdata;
    logic             exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, waited, nhs, nresp, hs_prev;
    logic exp_g;

    vecs[0]  = '{1'b0, 1'b0, 32'h100, MEM_WORD, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h102, MEM_HALF, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h101, MEM_BYTE, 32'h0,        32'h000000BE, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h203, MEM_BYTE, 32'h000000A5, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h200, MEM_WORD, 32'h0,        32'hA5223344, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h102, MEM_WORD, 32'h12345678, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h100, MEM_WORD, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h101, MEM_HALF, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h200, MEM_HALF, 32'hFFFFCAFE, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h200, MEM_WORD, 32'h0,        32'hA522CAFE, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h203, MEM_BYTE, 32'h0,        32'h000000A5, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h380, MEM_WORD, 32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h300, MEM_WORD, 32'h0BADF00D, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h300, MEM_WORD, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h302, MEM_BYTE, 32'h0,        32'h000000AD, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h305, MEM_BYTE, 32'h00000077, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h304, MEM_WORD, 32'h0,        32'h00007700, 1'b0};

    // Reset state, with both requests asserted to show ready stays low.
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_wr_enable", {31'h0, mif.wr_enable}, 32'h0);
    chk("rst_rd_addr", mif.rd_addr, 32'h0);
    chk("rst_rd_size", {30'h0, mif.rd_size}, {30'h0, MEM_WORD});
    chk("rst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    req_valid = 2'b00;
    mem_load = 1'b0;
    rst = 1'b0;

    // Tie: port 0 wins first after reset, then strict alternation.
    @(negedge clk);
    req_we = 2'b00;
    req_addr[0] = 32'h100; req_size[0] = MEM_WORD;
    req_addr[1] = 32'h200; req_size[1] = MEM_WORD;
    req_valid = 2'b11;
    grants = 0; waited = 0; exp_g = 1'b0;
    while (grants < 4 && waited < 100) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("tie_grant", {30'h0, req_ready}, exp_g ? 32'h2 : 32'h1);
        exp_q.push_back({exp_g, 1'b0, 1'b0, exp_g ? 32'h11223344 : 32'hDEADBEEF});
        hs_q.push_back(cyc);
        exp_g = ~exp_g;
        grants++;
      end
      @(negedge clk);
      waited++;
    end
    req_valid = 2'b00;
    chk("tie_grant_count", grants, 32'd4);
    drain();
`ifdef MEM_ARB_STATS_EN
    chk("stat_grant0", st_g0, 32'd2);
    chk("stat_grant1", st_g1, 32'd2);
    chk("stat_conflict", st_cf, 32'd4);
`endif

    // Reset while a write is in BUSY: the write must never reach memory.
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 32'h380; req_size[1] = MEM_WORD; req_wdata[1] = 32'h55555555;
    req_valid[1] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[1] && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    chk("rstw_grant", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rstw_in_busy", {30'h0, dbg_state}, {30'h0, BUSY});
    rst = 1'b1;
    #1;
    chk("rstw_state", {30'h0, dbg_state}, {30'h0, IDLE});
    chk("rstw_wr_enable", {31'h0, mif.wr_enable}, 32'h0);
    chk("rstw_rd_addr", mif.rd_addr, 32'h0);
    chk("rstw_resp_valid", {30'h0, resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstw_no_pulse", wen_cnt, 32'h0);
    chk("rstw_mem", {mem[10'h383], mem[10'h382], mem[10'h381], mem[10'h380]}, 32'h0);
    chk("rstw_idle", {30'h0, dbg_state}, {30'h0, IDLE});

    // Table-driven accesses, each checked by the response monitor.
    for (int i = 0; i < 17; i++) begin
      drive_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].size,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      drain();
    end

    // WAIT_CYCLES=0: held port-0 read gives a handshake every 3 cycles.
    @(negedge clk);
    req0_addr[0] = 32'h100; req0_size[0] = MEM_WORD; req0_we[0] = 1'b0;
    req0_valid[0] = 1'b1;
    nhs = 0; nresp = 0; hs_prev = -1;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (req0_ready[0]) begin
        if (hs_prev >= 0) chk("w0_spacing", cyc - hs_prev, 32'd3);
        hs_prev = cyc;
        nhs++;
      end
      if (resp0_valid != 2'b00) begin
        chk("w0_resp_valid", {30'h0, resp0_valid}, 32'h1);
        chk("w0_rdata", resp0_rdata, 32'hDEADBEEF);
        chk("w0_err", {31'h0, resp0_err}, 32'h0);
        chk("w0_latency", cyc - hs_prev, 32'd2);
        nresp++;
      end
      if (dbg0_state != IDLE) chk("w0_ready_low", {30'h0, req0_ready}, 32'h0);
      @(negedge clk);
    end
    req0_valid = 2'b00;
    chk("w0_handshakes", nhs, 32'd5);
    chk("w0_responses", nresp, 32'd5);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
